// File: rtl/rv4028_bus_ctrl.sv
// Multiplexed external bus controller: splits 32-bit CPU accesses into
// BUS_W-wide beats with SETUP/STROBE handshaking, wait states, timeout and bus release.
module rv4028_bus_ctrl #(
  parameter int BUS_W   = 16,
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cpu_req,
  input  logic                 cpu_we,
  input  logic [ADDR_W-1:0]    cpu_addr,
  input  logic [31:0]          cpu_wdata,
  input  logic [3:0]           cpu_wstrb,
  output logic [31:0]          cpu_rdata,
  output logic                 cpu_ready,
  output logic                 cpu_err,
  output logic [ADDR_W-1:0]    bus_addr,
  output logic                 bus_addr_oe,
  output logic [BUS_W-1:0]     bus_dout,
  input  logic [BUS_W-1:0]     bus_din,
  output logic                 bus_data_oe,
  output logic [BUS_W/8-1:0]   msk_n,
  output logic                 rd_n,
  output logic                 wr_n,
  output logic                 req_n,
  output logic                 iorq_n,
  output logic                 lo_addr_n,
  input  logic                 wait_n,
  input  logic                 busrq_n,
  output logic                 busack_n
);
  localparam int NB = 32 / BUS_W;
  localparam int BB = BUS_W / 8;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [TW-1:0] TLAST = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [2:0] {IDLE, SETUP, STROBE, DONE, RELEASED} state_t;
  state_t state, nxt;

  logic [1:0]    beat, first_beat, next_beat;
  logic          first_ok, next_ok;
  logic [NB-1:0] act;
  logic [TW-1:0] tcnt;
  logic          err_q, tmo, on_bus;
  logic [ADDR_W-1:0] beat_addr;

  // A write beat with an empty strobe slice is skipped; reads run every beat.
  always_comb begin
    act        = '0;
    first_ok   = 1'b0;
    first_beat = 2'd0;
    next_ok    = 1'b0;
    next_beat  = 2'd0;
    for (int k = 0; k < NB; k++)
      act[k] = !cpu_we || (|cpu_wstrb[k*BB +: BB]);
    for (int k = NB - 1; k >= 0; k--) begin
      if (act[k]) begin
        first_ok   = 1'b1;
        first_beat = 2'(k);
        if (k > int'(beat)) begin
          next_ok   = 1'b1;
          next_beat = 2'(k);
        end
      end
    end
  end

  assign tmo = (TIMEOUT != 0) && !wait_n && (tcnt == TLAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE:     if (!busrq_n)     nxt = RELEASED;
                else if (cpu_req) nxt = first_ok ? SETUP : DONE;
      SETUP:    nxt = STROBE;
      STROBE:   if (wait_n)       nxt = next_ok ? SETUP : DONE;
                else if (tmo)     nxt = DONE;
      DONE:     nxt = IDLE;
      RELEASED: if (busrq_n)      nxt = IDLE;
      default:  nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat      <= 2'd0;
      tcnt      <= '0;
      err_q     <= 1'b0;
      cpu_rdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          err_q <= 1'b0;
          if (busrq_n && cpu_req) beat <= first_beat;
        end
        SETUP: tcnt <= '0;
        STROBE: begin
          if (wait_n) begin
            if (!cpu_we) cpu_rdata[int'(beat)*BUS_W +: BUS_W] <= bus_din;
            if (next_ok) beat <= next_beat;
          end else begin
            tcnt <= tcnt + 1'b1;
            if (tmo) err_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign beat_addr = {cpu_addr[ADDR_W-1:2], 2'b00} + ADDR_W'(beat) * ADDR_W'(BB);

  always_comb begin
    on_bus      = (state == SETUP) || (state == STROBE);
    bus_addr    = on_bus ? beat_addr : '0;
    msk_n       = '1;
    if (on_bus) msk_n = cpu_we ? ~cpu_wstrb[int'(beat)*BB +: BB] : '0;
    bus_data_oe = on_bus && cpu_we;
    bus_dout    = bus_data_oe ? cpu_wdata[int'(beat)*BUS_W +: BUS_W] : '0;
    req_n       = !on_bus;
    rd_n        = !((state == STROBE) && !cpu_we);
    wr_n        = !((state == STROBE) && cpu_we);
    iorq_n      = on_bus ? ~bus_addr[ADDR_W-1] : 1'b1;
    lo_addr_n   = on_bus ? (|bus_addr[ADDR_W-1 -: 8]) : 1'b1;
    cpu_ready   = (state == DONE);
    cpu_err     = (state == DONE) && err_q;
    busack_n    = (state != RELEASED);
    bus_addr_oe = (state != RELEASED);
  end
endmodule

// File: tb/tb_rv4028_bus_ctrl.sv
// Directed bench: a 16-bit instance (TIMEOUT=4) and an 8-bit instance (TIMEOUT=255).
module tb_rv4028_bus_ctrl;
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;

  int n_tests = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- 16-bit instance ----------------
  logic        a_req = 0, a_we = 0, a_wait_n = 1, a_busrq_n = 1;
  logic [31:0] a_addr = 0, a_wdata = 0, a_rdata;
  logic [3:0]  a_wstrb = 0;
  logic [15:0] a_din = 0, a_dout;
  logic [31:0] a_baddr;
  logic [1:0]  a_msk_n;
  logic a_ready, a_err, a_aoe, a_doe, a_rd_n, a_wr_n, a_req_n, a_iorq_n, a_lo_n, a_busack_n;

  rv4028_bus_ctrl #(.BUS_W(16), .ADDR_W(32), .TIMEOUT(4)) dut16 (
    .clk(clk), .rst(rst), .cpu_req(a_req), .cpu_we(a_we), .cpu_addr(a_addr),
    .cpu_wdata(a_wdata), .cpu_wstrb(a_wstrb), .cpu_rdata(a_rdata), .cpu_ready(a_ready),
    .cpu_err(a_err), .bus_addr(a_baddr), .bus_addr_oe(a_aoe), .bus_dout(a_dout),
    .bus_din(a_din), .bus_data_oe(a_doe), .msk_n(a_msk_n), .rd_n(a_rd_n), .wr_n(a_wr_n),
    .req_n(a_req_n), .iorq_n(a_iorq_n), .lo_addr_n(a_lo_n), .wait_n(a_wait_n),
    .busrq_n(a_busrq_n), .busack_n(a_busack_n));

  // ---------------- 8-bit instance ----------------
  logic        b_req = 0, b_we = 0, b_wait_n = 1, b_busrq_n = 1;
  logic [31:0] b_addr = 0, b_wdata = 0, b_rdata;
  logic [3:0]  b_wstrb = 0;
  logic [7:0]  b_din = 0, b_dout;
  logic [31:0] b_baddr;
  logic [0:0]  b_msk_n;
  logic b_ready, b_err, b_aoe, b_doe, b_rd_n, b_wr_n, b_req_n, b_iorq_n, b_lo_n, b_busack_n;

  rv4028_bus_ctrl #(.BUS_W(8), .ADDR_W(32), .TIMEOUT(255)) dut8 (
    .clk(clk), .rst(rst), .cpu_req(b_req), .cpu_we(b_we), .cpu_addr(b_addr),
    .cpu_wdata(b_wdata), .cpu_wstrb(b_wstrb), .cpu_rdata(b_rdata), .cpu_ready(b_ready),
    .cpu_err(b_err), .bus_addr(b_baddr), .bus_addr_oe(b_aoe), .bus_dout(b_dout),
    .bus_din(b_din), .bus_data_oe(b_doe), .msk_n(b_msk_n), .rd_n(b_rd_n), .wr_n(b_wr_n),
    .req_n(b_req_n), .iorq_n(b_iorq_n), .lo_addr_n(b_lo_n), .wait_n(b_wait_n),
    .busrq_n(b_busrq_n), .busack_n(b_busack_n));

  // Observations gathered while a transaction runs.
  int          cyc, reqn_cnt, strb_cnt, stall_left, stall_strb;
  logic [31:0] f_addr, l_addr, rdata_at_rdy, stall_addr;
  logic [15:0] l_dout;
  logic [1:0]  l_msk;
  logic        f_iorq, f_lo, l_doe, err_at_rdy, done;

  task automatic start_a(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                         input logic [3:0] ws);
    @(negedge clk);
    a_we = we; a_addr = addr; a_wdata = wd; a_wstrb = ws; a_req = 1'b1;
  endtask

  // Runs until cpu_ready; the bus model returns 0xBEEF / 0xDEAD for the low / high halfword.
  task automatic wait_a();
    cyc = 0; reqn_cnt = 0; strb_cnt = 0; done = 1'b0;
    while (!done && cyc < 40) begin
      @(negedge clk);
      cyc++;
      a_din = a_baddr[1] ? 16'hDEAD : 16'hBEEF;
      if (!a_req_n) begin
        reqn_cnt++;
        if (reqn_cnt == 1) begin f_addr = a_baddr; f_iorq = a_iorq_n; f_lo = a_lo_n; end
        l_addr = a_baddr; l_dout = a_dout; l_msk = a_msk_n; l_doe = a_doe;
      end
      if (!a_rd_n || !a_wr_n) strb_cnt++;
      if (a_ready) begin
        done = 1'b1; rdata_at_rdy = a_rdata; err_at_rdy = a_err;
      end
    end
    if (!done) chk("a_ready_bound", 0, 1);
    a_req = 1'b0;
  endtask

  task automatic wait_b();
    cyc = 0; reqn_cnt = 0; stall_strb = 0; done = 1'b0;
    while (!done && cyc < 60) begin
      @(negedge clk);
      cyc++;
      b_din = b_baddr[7:0] ^ 8'hA5;
      if (!b_req_n) begin
        reqn_cnt++;
        l_addr = b_baddr; l_dout = {8'h00, b_dout};
        if (reqn_cnt == 1) f_addr = b_baddr;
      end
      if (!b_rd_n && b_baddr == stall_addr) stall_strb++;
      if (!b_rd_n && b_baddr == stall_addr && stall_left > 0) begin
        b_wait_n = 1'b0; stall_left--;
      end else b_wait_n = 1'b1;
      if (b_ready) begin
        done = 1'b1; rdata_at_rdy = b_rdata; err_at_rdy = b_err;
      end
    end
    if (!done) chk("b_ready_bound", 0, 1);
    b_req = 1'b0; b_wait_n = 1'b1;
  endtask

  initial begin
    // Reset state
    #2;
    chk("rst_strobes", {a_req_n, a_rd_n, a_wr_n, a_iorq_n, a_lo_n, a_busack_n}, 6'b111111);
    chk("rst_msk", a_msk_n, 2'b11);
    chk("rst_oe", {a_aoe, a_doe}, 2'b10);
    chk("rst_addr", a_baddr, 0);
    chk("rst_cpu", {a_ready, a_err, a_rdata}, 34'h0);
    @(negedge clk); @(negedge clk); rst = 1'b0;

    // Two-beat read at 0x1000
    start_a(1'b0, 32'h0000_1000, 0, 0);
    wait_a();
    chk("rd_latency", cyc, 5);
    chk("rd_data", rdata_at_rdy, 32'hDEADBEEF);
    chk("rd_err", err_at_rdy, 0);
    chk("rd_addr0", f_addr, 32'h1000);
    chk("rd_addr1", l_addr, 32'h1002);
    chk("rd_iorq_lo", {f_iorq, f_lo}, 2'b10);
    chk("rd_msk", l_msk, 2'b00);
    chk("rd_strb", strb_cnt, 2);

    // Single upper-halfword write
    start_a(1'b1, 32'h8000_0004, 32'h1234_5678, 4'b1100);
    wait_a();
    chk("wr_latency", cyc, 3);
    chk("wr_addr", l_addr, 32'h8000_0006);
    chk("wr_dout", l_dout, 16'h1234);
    chk("wr_msk", l_msk, 2'b00);
    chk("wr_iorq_lo", {f_iorq, f_lo}, 2'b01);
    chk("wr_doe", l_doe, 1);
    chk("wr_beats", reqn_cnt, 2);

    // Partial strobe mask on the low halfword
    start_a(1'b1, 32'h0000_0020, 32'hCAFE_F00D, 4'b0001);
    wait_a();
    chk("wrp_addr", l_addr, 32'h20);
    chk("wrp_msk", l_msk, 2'b10);
    chk("wrp_dout", l_dout, 16'hF00D);

    // Timeout with wait_n stuck low
    a_wait_n = 1'b0;
    start_a(1'b0, 32'h0000_1000, 0, 0);
    wait_a();
    a_wait_n = 1'b1;
    chk("tmo_latency", cyc, 6);
    chk("tmo_err", err_at_rdy, 1);
    chk("tmo_strb", strb_cnt, 4);
    chk("tmo_one_beat", l_addr, 32'h1000);

    // Empty-strobe write
    start_a(1'b1, 32'h0000_0100, 32'h1111_2222, 4'b0000);
    wait_a();
    chk("nostrb_latency", cyc, 1);
    chk("nostrb_req", reqn_cnt, 0);
    chk("nostrb_err", err_at_rdy, 0);

    // Bus release wins over a simultaneous request
    start_a(1'b1, 32'h0000_0040, 32'hA1B2_C3D4, 4'b1111);
    a_busrq_n = 1'b0;
    @(negedge clk);
    chk("rel_busack", a_busack_n, 0);
    chk("rel_oe", {a_aoe, a_doe}, 2'b00);
    chk("rel_strobes", {a_req_n, a_rd_n, a_wr_n}, 3'b111);
    @(negedge clk);
    chk("rel_hold", {a_busack_n, a_req_n}, 2'b01);
    a_busrq_n = 1'b1;
    wait_a();
    chk("rel_latency", cyc, 6);
    chk("rel_last_dout", l_dout, 16'hA1B2);
    chk("rel_err", err_at_rdy, 0);

    // Reset during STROBE
    start_a(1'b0, 32'h0000_1000, 0, 0);
    @(negedge clk); @(negedge clk);
    chk("mid_strobe", a_rd_n, 0);
    #1 rst = 1'b1;
    #1 chk("rst_mid_strobes", {a_req_n, a_rd_n, a_wr_n, a_ready}, 4'b1110);
    @(negedge clk);
    chk("rst_mid_noready", a_ready, 0);
    a_req = 1'b0;
    @(negedge clk); rst = 1'b0;
    start_a(1'b0, 32'h0000_1000, 0, 0);
    wait_a();
    chk("post_rst_latency", cyc, 5);
    chk("post_rst_data", rdata_at_rdy, 32'hDEADBEEF);

    // 8-bit read, three wait states on beat 2
    stall_addr = 32'h2002; stall_left = 3;
    @(negedge clk);
    b_we = 1'b0; b_addr = 32'h0000_2000; b_req = 1'b1;
    wait_b();
    chk("b_rd_latency", cyc, 12);
    chk("b_rd_stall_strb", stall_strb, 4);
    chk("b_rd_data", rdata_at_rdy, 32'hA6A7A4A5);
    chk("b_rd_err", err_at_rdy, 0);

    // 8-bit sparse write: bytes 0 and 2
    stall_addr = 32'hFFFF_FFFF; stall_left = 0;
    @(negedge clk);
    b_we = 1'b1; b_addr = 32'h0000_3000; b_wdata = 32'hAABBCCDD; b_wstrb = 4'b0101; b_req = 1'b1;
    wait_b();
    chk("b_wr_latency", cyc, 5);
    chk("b_wr_first", f_addr, 32'h3000);
    chk("b_wr_last", l_addr, 32'h3002);
    chk("b_wr_dout", l_dout, 16'h00BB);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
